muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one result bit per cycle, done pulses DATA_WIDTH+2 cycles after accept.
// Single-request in flight (in_ready only in IDLE); optional MULDIV_FAST_MUL_EN gives a one-cycle multiplier.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]  cnt;
  logic [2*W:0]   acc;       // mul: {partial, multiplier}; div: low W bits dividend/quotient
  logic [W-1:0]   rem;
  logic [W-1:0]   mcand;     // multiplicand or divisor magnitude
  logic [W-1:0]   rs_q;
  logic           is_mul_q;
  logic           neg_q;
  logic           rem_neg_q;
  logic           dz_q;

  logic           accept;
  logic           op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
  logic           is_mul_in, is_div_in, is_long_in, sgn_in;
  logic [W-1:0]   rs_mag, rt_mag;

  assign accept    = in_valid && in_ready;
  assign op_mult   = (op == OP_WIDTH'(0));
  assign op_multu  = (op == OP_WIDTH'(1));
  assign op_div    = (op == OP_WIDTH'(2));
  assign op_divu   = (op == OP_WIDTH'(3));
  assign op_mthi   = (op == OP_WIDTH'(4));
  assign op_mtlo   = (op == OP_WIDTH'(5));
  assign is_mul_in  = op_mult || op_multu;
  assign is_div_in  = op_div || op_divu;
  assign is_long_in = is_mul_in || is_div_in;
  assign sgn_in     = op_mult || op_div;

  assign rs_mag = (sgn_in && rs[W-1]) ? -rs : rs;
  assign rt_mag = (sgn_in && rt[W-1]) ? -rt : rt;

  // Iteration datapath
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   div_sub;

  assign mul_sum   = acc[2*W:W] + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
  assign div_shift = {rem, acc[W-1]};
  assign div_ge    = (div_shift >= {1'b0, mcand});
  assign div_sub   = div_shift[W-1:0] - mcand;

  // Result fix-up, applied in FIN
  logic [2*W-1:0] mag_prod;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

`ifdef MULDIV_FAST_MUL_EN
  assign mag_prod = {{W{1'b0}}, mcand} * {{W{1'b0}}, acc[W-1:0]};
`else
  assign mag_prod = acc[2*W-1:0];
`endif
  assign prod_fix = neg_q ? -mag_prod : mag_prod;
  assign quo_fix  = neg_q ? -acc[W-1:0] : acc[W-1:0];
  assign rem_fix  = rem_neg_q ? -rem : rem;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_long_in) begin
`ifdef MULDIV_FAST_MUL_EN
          state_nxt = is_mul_in ? FIN : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == CW'(W-1)) begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready = (state == IDLE) && !rst;
    busy     = !in_ready;
  end

  // Datapath and architectural registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      rem       <= '0;
      mcand     <= '0;
      rs_q      <= '0;
      is_mul_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done <= 1'b0;

      if (accept) begin
        div_zero <= 1'b0;
        cnt      <= '0;
        if (op_mthi) begin
          hi   <= rs;
          done <= 1'b1;
        end else if (op_mtlo) begin
          lo   <= rs;
          done <= 1'b1;
        end else if (is_long_in) begin
          acc       <= {{(W+1){1'b0}}, rs_mag};
          rem       <= '0;
          mcand     <= rt_mag;
          rs_q      <= rs;
          is_mul_q  <= is_mul_in;
          neg_q     <= sgn_in && (rs[W-1] ^ rt[W-1]);
          rem_neg_q <= sgn_in && rs[W-1];
          dz_q      <= is_div_in && (rt == '0);
        end else begin
          done <= 1'b1;
        end
      end

      if (state == RUN && !flush) begin
        cnt <= cnt + CW'(1);
        if (is_mul_q) begin
          acc <= {1'b0, mul_sum, acc[W-1:1]};
        end else begin
          rem          <= div_ge ? div_sub : div_shift[W-1:0];
          acc[W-1:0]   <= {acc[W-2:0], div_ge};
        end
      end

      // Flush wins over the final write
      if (state == FIN && !flush) begin
        done <= 1'b1;
        if (is_mul_q) begin
          {hi, lo} <= prod_fix;
        end else if (dz_q) begin
          hi       <= rs_q;
          lo       <= '1;
          div_zero <= 1'b1;
        end else begin
          hi <= rem_fix;
          lo <= quo_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (DATA_WIDTH=32): vector table, directed corner sequences, random vs arithmetic model.
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  rs, rt;
  logic          flush;
  logic [W-1:0]  hi, lo;
  logic          busy, done, div_zero;

  muldiv_unit #(.DATA_WIDTH(W), .OP_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs(rs), .rt(rt), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;
  int waitc = 0;

  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic         m_dz = 1'b0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] rs, rt, hi, lo;
    logic         dz;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural rules
  task automatic model_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    longint sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_dz = 1'b0;
    lat = 1;
    case (o)
      3'd0: begin p = sa * sb; {m_hi, m_lo} = p; lat = MUL_LAT; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = up; lat = MUL_LAT; end
      3'd2, 3'd3: begin
        lat = DIV_LAT;
        if (b == 0) begin
          m_hi = a; m_lo = '1; m_dz = 1'b1;
        end else if (o == 3'd2) begin
          p = sa / sb; m_lo = p[31:0];
          p = sa % sb; m_hi = p[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
    waitc = n;
    in_valid = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    if (!done) chk("done_timeout", {63'd0, done}, 64'd1);
    lat = cyc - acc_cyc + 1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    start_op(o, a, b);
    wait_done(lat);
  endtask

  task automatic no_done_for(input string name, input int ncyc);
    int seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  function automatic logic [W-1:0] pick(input int sel);
    case (sel)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, exp_lat;
    logic [2:0] o;
    logic [W-1:0] a, b;

    tbl[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tbl[1]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[2]  = '{3'd3, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
    tbl[3]  = '{3'd3, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1};
    tbl[4]  = '{3'd5, 32'd5,        32'd0,        32'h12345678, 32'd5,        1'b0};
    tbl[5]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
    tbl[7]  = '{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0};
    tbl[8]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    tbl[9]  = '{3'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    tbl[10] = '{3'd6, 32'd1,        32'd1,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0};
    tbl[11] = '{3'd4, 32'd9,        32'd0,        32'd9,        32'hFFFFFFFF, 1'b0};
    tbl[12] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0};
    tbl[13] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        1'b0};
    tbl[14] = '{3'd0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};
    tbl[15] = '{3'd7, 32'd3,        32'd3,        32'hC0000000, 32'h80000000, 1'b0};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; op = '0; rs = '0; rt = '0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz", {63'd0, div_zero}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Vector table, issued back-to-back
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].rs, tbl[i].rt, lat);
      model_op(tbl[i].op, tbl[i].rs, tbl[i].rt, exp_lat);
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(exp_lat));
      chk($sformatf("tbl%0d_hi", i), {32'd0, hi}, {32'd0, tbl[i].hi});
      chk($sformatf("tbl%0d_lo", i), {32'd0, lo}, {32'd0, tbl[i].lo});
      chk($sformatf("tbl%0d_dz", i), {63'd0, div_zero}, {63'd0, tbl[i].dz});
    end

    // Back-to-back MTHI accepted in the DIV done cycle
    run_op(3'd2, 32'd100, 32'd7, lat);
    model_op(3'd2, 32'd100, 32'd7, exp_lat);
    chk("b2b_div_lat", 64'(lat), 64'(exp_lat));
    run_op(3'd4, 32'd9, 32'd0, lat);
    model_op(3'd4, 32'd9, 32'd0, exp_lat);
    chk("b2b_no_bubble", 64'(waitc), 64'd0);
    chk("b2b_mthi_lat", 64'(lat), 64'd1);
    chk("b2b_hi", {32'd0, hi}, 64'd9);
    chk("b2b_lo", {32'd0, lo}, 64'd14);

    // Flush during RUN at c+10
`ifdef MULDIV_FAST_MUL_EN
    o = 3'd3;
`else
    o = 3'd1;
`endif
    start_op(o, 32'hFFFFFFFF, 32'hFFFFFFFF);
    m_dz = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_run_in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_run_done", {63'd0, done}, 64'd0);
    no_done_for("flush_run_no_done", 40);
    chk("flush_run_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("flush_run_lo", {32'd0, lo}, {32'd0, m_lo});

    // Flush in FIN (c+33) beats the write
    start_op(3'd2, 32'd100, 32'd7);
    for (int i = 0; i < W + 1; i++) @(negedge clk);
    chk("flush_fin_busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    no_done_for("flush_fin_no_done", 40);
    chk("flush_fin_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("flush_fin_lo", {32'd0, lo}, {32'd0, m_lo});

    // Flush asserted while IDLE (in the accept cycle) is ignored
    flush = 1'b1;
    start_op(3'd3, 32'd7, 32'd2);
    flush = 1'b0;
    wait_done(lat);
    model_op(3'd3, 32'd7, 32'd2, exp_lat);
    chk("flush_idle_lat", 64'(lat), 64'(exp_lat));
    chk("flush_idle_lo", {32'd0, lo}, 64'd3);

    // Request while busy is dropped, not queued
    start_op(3'd3, 32'd9, 32'd2);
    for (int i = 0; i < 3; i++) @(negedge clk);
    in_valid = 1'b1; op = 3'd4; rs = 32'hDEAD;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(lat);
    model_op(3'd3, 32'd9, 32'd2, exp_lat);
    chk("busy_ign_lat", 64'(lat), 64'(exp_lat));
    chk("busy_ign_hi", {32'd0, hi}, 64'd1);
    chk("busy_ign_lo", {32'd0, lo}, 64'd4);
    no_done_for("busy_ign_no_extra", 5);

    // Reset mid-operation at c+5
    start_op(3'd2, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    #1;
    chk("midrst_in_ready_after", {63'd0, in_ready}, 64'd1);
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    no_done_for("midrst_no_done", 40);

    // Randomized against the model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick($urandom_range(0, 8));
      b = pick($urandom_range(0, 8));
      run_op(o, a, b, lat);
      model_op(o, a, b, exp_lat);
      chk($sformatf("rnd%0d_op%0d_lat", i, o), 64'(lat), 64'(exp_lat));
      chk($sformatf("rnd%0d_op%0d_hi", i, o), {32'd0, hi}, {32'd0, m_hi});
      chk($sformatf("rnd%0d_op%0d_lo", i, o), {32'd0, lo}, {32'd0, m_lo});
      chk($sformatf("rnd%0d_op%0d_dz", i, o), {63'd0, div_zero}, {63'd0, m_dz});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
